// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port NoC router.
// Contents:
//   N_PORTS       - number of router ports (N, S, E, W, L)
//   port_e        - port index encoding, N=0 .. L=4
//   alloc_state_e - output-port allocator FSM states
package noc_pkg;

  localparam int N_PORTS = 5;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Finds the first set bit of req_i, starting at index ptr_i and wrapping
// modulo N_PORTS. Shared by the output-port allocator and the input-side
// virtual-channel allocator.
// Ports:
//   req_i     - request vector, one bit per port
//   ptr_i     - highest-priority index (must be < N_PORTS)
//   any_o     - at least one request is set
//   sel_idx_o - index of the selected requester (0 when any_o is low)
module rr_picker #(
  parameter int N_PORTS = 5,
  parameter int PTR_W   = 3
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [PTR_W-1:0]   sel_idx_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    any_o     = 1'b0;
    sel_idx_o = '0;
    idx       = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      // Candidate index = (ptr + k) mod N_PORTS without a divider.
      if (int'(ptr_i) + k >= N_PORTS) begin
        idx = PTR_W'(int'(ptr_i) + k - N_PORTS);
      end else begin
        idx = PTR_W'(int'(ptr_i) + k);
      end
      if (!any_o && req_i[idx]) begin
        any_o     = 1'b1;
        sel_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/out_port_alloc.sv
// Per-output-port wormhole allocator for the 5-port NoC router.
// One output is shared among the N, S, E, W and L inputs. A round-robin
// winner is locked onto the output until its tail flit is forwarded; each
// forwarded flit is gated on downstream credit and returns a decrement
// pulse to the flow-control credit counter.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   req_i       - per-input head-flit request for this output
//   valid_i     - per-input flit valid for this output
//   tail_i      - per-input tail marker, qualified by valid_i
//   credit_en_i - downstream has at least one free slot
//   grant_o     - registered one-hot grant, zero when idle
//   xfer_o      - a flit crosses the output this cycle
//   decr_o      - credit decrement pulse, same as xfer_o
//   busy_o      - registered, high while a packet holds the output
module out_port_alloc #(
  parameter int N_PORTS = 5,
  parameter int PTR_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req_i,
  input  logic [N_PORTS-1:0] valid_i,
  input  logic [N_PORTS-1:0] tail_i,
  input  logic               credit_en_i,
  output logic [N_PORTS-1:0] grant_o,
  output logic               xfer_o,
  output logic               decr_o,
  output logic               busy_o
);

  import noc_pkg::alloc_state_e;
  import noc_pkg::IDLE;
  import noc_pkg::LOCKED;

  alloc_state_e state_q;
  alloc_state_e state_d;

  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [N_PORTS-1:0] grant_q;

  logic               pick_any;
  logic [PTR_W-1:0]   pick_idx;

  logic               take;      // IDLE -> LOCKED this cycle
  logic               release_c; // tail forwarded, LOCKED -> IDLE
  logic               xfer;

  rr_picker #(
    .N_PORTS (N_PORTS),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req_i     (req_i),
    .ptr_i     (rr_ptr_q),
    .any_o     (pick_any),
    .sel_idx_o (pick_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take)      state_d = LOCKED;
      LOCKED:  if (release_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / event logic. Requests are looked at only while idle; once
  // locked, only the owner's valid/tail matter. Reset forces xfer low so
  // the credit counter never sees a pulse for an abandoned packet.
  always_comb begin
    take      = 1'b0;
    xfer      = 1'b0;
    release_c = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) begin
        take = pick_any & credit_en_i;
      end else begin
        xfer      = valid_i[owner_q] & credit_en_i;
        release_c = xfer & tail_i[owner_q];
      end
    end
  end

  // Owner, pointer and grant registers. The pointer moves only on release,
  // so a long packet does not cost the next requester its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else if (take) begin
      owner_q <= pick_idx;
      grant_q <= {{(N_PORTS-1){1'b0}}, 1'b1} << pick_idx;
    end else if (release_c) begin
      grant_q  <= '0;
      rr_ptr_q <= (owner_q == PTR_W'(N_PORTS-1)) ? '0 : owner_q + 1'b1;
    end
  end

  assign grant_o = grant_q;
  assign xfer_o  = xfer;
  assign decr_o  = xfer;
  assign busy_o  = (state_q == LOCKED);

endmodule

// File: tb/tb_out_port_alloc.sv
module tb_out_port_alloc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req_i;
  logic [4:0] valid_i;
  logic [4:0] tail_i;
  logic       credit_en_i;
  logic [4:0] grant_o;
  logic       xfer_o;
  logic       decr_o;
  logic       busy_o;

  out_port_alloc #(
    .N_PORTS (5),
    .PTR_W   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .valid_i     (valid_i),
    .tail_i      (tail_i),
    .credit_en_i (credit_en_i),
    .grant_o     (grant_o),
    .xfer_o      (xfer_o),
    .decr_o      (decr_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cnt = 0;
  bit chk_en   = 0;

  // Reference model: who holds the output and whose turn is next.
  bit m_locked = 0;
  int m_owner  = 0;
  int m_ptr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    logic [4:0] eg;
    logic       ex;
    eg = m_locked ? (5'b00001 << m_owner) : 5'b00000;
    ex = !rst && m_locked && valid_i[m_owner] && credit_en_i;
    chk("grant",   {27'd0, grant_o}, {27'd0, eg});
    chk("xfer",    {31'd0, xfer_o},  {31'd0, ex});
    chk("decr",    {31'd0, decr_o},  {31'd0, ex});
    chk("busy",    {31'd0, busy_o},  {31'd0, m_locked});
    chk("onehot0", {31'd0, $onehot0(grant_o)}, 32'd1);
  endtask

  task automatic model_update();
    if (rst) begin
      m_locked = 0;
      m_owner  = 0;
      m_ptr    = 0;
    end else if (!m_locked) begin
      if (credit_en_i && req_i != 5'b0) begin
        for (int k = 0; k < 5; k++) begin
          if (!m_locked && req_i[(m_ptr + k) % 5]) begin
            m_owner  = (m_ptr + k) % 5;
            m_locked = 1;
          end
        end
      end
    end else if (valid_i[m_owner] && credit_en_i && tail_i[m_owner]) begin
      m_locked = 0;
      m_ptr    = (m_owner + 1) % 5;
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return just after.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) compare();
    if (decr_o === 1'b1) xfer_cnt++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    req_i = 0; valid_i = 0; tail_i = 0; credit_en_i = 1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1; cyc();
    rst = 0;
  endtask

  logic [4:0] seq [11];
  logic [4:0] exp_seq [11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_seq = '{5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100, 5'b00000,
                5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b00001};
    quiet();
    credit_en_i = 0;
    rst = 1;
    // 1. reset, then idle
    cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    xfer_cnt = 0;
    repeat (3) cyc();
    chk("t1_grant", {27'd0, grant_o}, 32'h0);
    chk("t1_busy",  {31'd0, busy_o},  32'h0);
    chk("t1_xfers", xfer_cnt, 32'd0);

    // 2. single E request, 3-flit packet
    do_reset();
    req_i = 5'b00100; valid_i = 5'b00100; credit_en_i = 1;
    cyc();
    chk("t2_grant", {27'd0, grant_o}, 32'h04);
    xfer_cnt = 0;
    req_i = 0;
    cyc(); cyc();
    tail_i = 5'b00100;
    cyc();
    chk("t2_release", {27'd0, grant_o}, 32'h0);
    chk("t2_xfers", xfer_cnt, 32'd3);
    quiet(); req_i = 5'b11111;
    cyc();
    chk("t2_ptr_next_W", {27'd0, grant_o}, 32'h08);
    quiet(); valid_i = 5'b01000; tail_i = 5'b01000;
    cyc();

    // 3. round-robin order and wrap with single-flit packets
    do_reset();
    req_i = 5'b11111; valid_i = 5'b11111; tail_i = 5'b11111; credit_en_i = 1;
    for (int i = 0; i < 11; i++) begin
      cyc();
      seq[i] = grant_o;
    end
    for (int i = 0; i < 11; i++) chk($sformatf("t3_seq%0d", i), {27'd0, seq[i]}, {27'd0, exp_seq[i]});

    // 4. credit stall on owner S
    do_reset();
    req_i = 5'b00010; valid_i = 5'b00010; credit_en_i = 1;
    cyc();
    chk("t4_grant", {27'd0, grant_o}, 32'h02);
    xfer_cnt = 0;
    cyc();
    credit_en_i = 0;
    repeat (4) begin
      cyc();
      chk("t4_hold", {27'd0, grant_o}, 32'h02);
    end
    chk("t4_stall_xfers", xfer_cnt, 32'd1);
    credit_en_i = 1;
    cyc();
    tail_i = 5'b00010;
    cyc();
    chk("t4_release", {27'd0, grant_o}, 32'h0);
    chk("t4_xfers", xfer_cnt, 32'd3);

    // 5. no credit at arbitration
    do_reset();
    req_i = 5'b00001; credit_en_i = 0;
    repeat (3) cyc();
    chk("t5_nogrant", {27'd0, grant_o}, 32'h0);
    credit_en_i = 1;
    cyc();
    chk("t5_grant", {27'd0, grant_o}, 32'h01);
    valid_i = 5'b00001; tail_i = 5'b00001;
    cyc();

    // 6. W owner, N noise, reset mid-packet
    do_reset();
    req_i = 5'b01000; credit_en_i = 1;
    cyc();
    chk("t6_grant", {27'd0, grant_o}, 32'h08);
    xfer_cnt = 0;
    valid_i = 5'b01001; tail_i = 5'b00001;
    cyc(); cyc();
    valid_i = 5'b00001; tail_i = 5'b00001;
    cyc();
    chk("t6_noise_xfers", xfer_cnt, 32'd2);
    chk("t6_held", {27'd0, grant_o}, 32'h08);
    rst = 1;
    cyc();
    rst = 0;
    chk("t6_reset", {27'd0, grant_o}, 32'h0);
    quiet(); req_i = 5'b11111;
    cyc();
    chk("t6_first_N", {27'd0, grant_o}, 32'h01);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      req_i       = 5'($urandom);
      valid_i     = 5'($urandom);
      tail_i      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      credit_en_i = ($urandom_range(0, 4) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/out_port_alloc.md
Name: out_port_alloc

Overview:
- Per-output-port wormhole allocator for the 5-port NoC router.
- Shares one output port among the N, S, E, W and L input ports.
  - Grants one requester at a time using round-robin priority.
  - Holds the grant until that packet's tail flit has been forwarded.
- Gates every flit transfer on the downstream credit indication from the flow-control credit counter.
- Returns a one-cycle decrement pulse to that counter for each flit sent.

Parameters:
- N_PORTS, 5, number of requesting input ports; index order N=0, S=1, E=2, W=3, L=4.
- PTR_W, 3, width of the round-robin pointer and owner index; must satisfy 2**PTR_W >= N_PORTS.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  N_PORTS  per-input request; bit i high means input i holds a head flit routed to this output.
- valid_i  input  N_PORTS  per-input flit-valid for this output.
- tail_i  input  N_PORTS  per-input tail marker, qualified by valid_i.
- credit_en_i  input  1  downstream has at least one free buffer slot (credit count > 0).
- grant_o  output  N_PORTS  registered one-hot grant; all zero when idle.
- xfer_o  output  1  combinational; a flit crosses the output this cycle.
- decr_o  output  1  combinational; credit decrement pulse to the FCC, identical to xfer_o.
- busy_o  output  1  registered; high while the state is LOCKED.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, grant_o=0, busy_o=0, rr_ptr=0 (N), owner=0.
  - xfer_o and decr_o are 0 throughout the reset cycle.
  - A reset mid-packet abandons the packet; there is no partial release.
- FSM states: IDLE, LOCKED.
- IDLE state:
  - If |req_i and credit_en_i: select the first requesting index, searching from rr_ptr upward mod N_PORTS.
  - On the next posedge: owner=sel, grant_o=onehot(sel), state=LOCKED.
  - If credit_en_i=0, no grant is issued, even with requests pending.
  - No flit transfers in IDLE: xfer_o=0.
- LOCKED state:
  - xfer_o = decr_o = valid_i[owner] & credit_en_i.
  - When xfer_o=1 and tail_i[owner]=1: on the next posedge grant_o=0, state=IDLE, rr_ptr=(owner+1) mod N_PORTS.
  - Otherwise the grant is held.
- Grant latency:
  - First grant is visible one cycle after request plus credit.
  - First flit can transfer in that same granted cycle.
- Minimum occupancy:
  - A single-flit packet (valid and tail together on the first granted cycle) occupies 2 cycles: 1 grant cycle, then 1 IDLE cycle.
  - Back-to-back packets from different inputs are separated by exactly one IDLE cycle.
- Credit stall:
  - If credit_en_i drops while LOCKED, xfer_o=0 and the grant is held indefinitely.
  - No timeout; the owner is never preempted.
- Requester changes while LOCKED:
  - req_i changes (including the owner deasserting req_i) are ignored.
  - Only a tail transfer releases the grant.
- valid_i/tail_i from non-owner inputs never cause xfer_o.
- Pointer update: the pointer advances only on release, never on grant alone. This gives fairness: each of 5 continuously requesting inputs is served within 5 packets.
- Wrap-around: owner=4 (L) releases to rr_ptr=0 (N).
- Invariant: grant_o is one-hot or zero at every cycle; the bench asserts $onehot0(grant_o).

Decomposition:
- Shared package noc_pkg:
  - Port index enum port_e {NORTH=0, SOUTH=1, EAST=2, WEST=3, LOCAL=4}.
  - Constant N_PORTS=5.
  - FSM typedef alloc_state_e {IDLE, LOCKED}.
- Sub-module rr_picker:
  - Purely combinational.
  - Inputs: req vector and pointer. Outputs: any_o and sel_idx_o.
  - Reused by the input-side virtual-channel allocator.
- out_port_alloc instantiates one rr_picker and owns the FSM, owner, pointer and grant registers.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then req_i=0 -> grant_o=00000, busy_o=0, xfer_o=0 every cycle.
2. Single request, 3-flit packet:
   - Stimulus: req_i=00100 (E), credit_en_i=1, valid_i[2]=1, tail on flit 3.
   - Response: grant_o=00100 one cycle later; xfer_o/decr_o high 3 cycles; grant_o=0 and rr_ptr=3 the cycle after the tail.
3. Round-robin order and wrap: all req_i=11111, 1-flit packets, credit always 1 -> grant sequence N, S, E, W, L, N, each separated by one IDLE cycle.
4. Credit stall:
   - Stimulus: owner=S, mid-packet credit_en_i=0 for 4 cycles with valid_i[1]=1.
   - Response: xfer_o=0 and grant_o=00010 held for those 4 cycles; transfer resumes on credit return; total decr_o pulses equal the flit count.
5. No credit at arbitration: req_i=00001, credit_en_i=0 for 3 cycles -> no grant; grant_o=00001 one cycle after credit_en_i rises.
6. Reset mid-packet and non-owner noise:
   - Stimulus: owner=W, flits 1-2 sent while N asserts valid_i and tail_i (no xfer_o from N); rst=1 before the tail.
   - Response: grant_o=0 and rr_ptr=0 the next cycle; a subsequent req_i=11111 grants N first.
